// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command/response bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StFail
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Falling edge on which the stop bit is presented; the next fall carries the ACK.
  localparam logic [3:0] LastBitCnt = 4'd10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_CLK/PS2_DATA plus falling-edge detect on the synced clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);
  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], clk_i};
    data_sync_d = {data_sync_q[0], data_i};
    clk_prev_d  = clk_sync_q[1];
  end

  // Idle bus level is high; resetting to 1 avoids a spurious fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_s_o    = clk_sync_q[1];
  assign data_s_o   = data_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pin enables and ACK check.
// Optional automatic resend on NACK/timeout when PS2_TX_RESEND_EN is defined.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
`ifdef PS2_TX_RESEND_EN
  ,
  parameter int unsigned MAX_RETRY = 2
`endif
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_i     (ps2_clk_in),
    .data_i    (ps2_data_in),
    .clk_s_o   (clk_s),
    .data_s_o  (data_s),
    .clk_fall_o(clk_fall)
  );

  ps2_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [8:0]      shreg_q, shreg_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            tx_ready_q, tx_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fail;

`ifdef PS2_TX_RESEND_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [8:0]        frame_q, frame_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    data_oe_d = data_oe_q;
    fail      = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retry_d   = retry_q;
    frame_d   = frame_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (tx.tx_valid && tx_ready_q) begin
          shreg_d = {odd_parity(tx.tx_data), tx.tx_data};
          cnt_d   = '0;
          state_d = StInhibit;
`ifdef PS2_TX_RESEND_EN
          retry_d = '0;
          frame_d = {odd_parity(tx.tx_data), tx.tx_data};
`endif
        end
      end
      StInhibit: begin
        if (cnt_q == InhLast) state_d = StReq;
        else cnt_d = cnt_q + CntW'(1);
      end
      StReq: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = StShift;
      end
      StShift: begin
        // Host changes data while the device holds the clock low.
        if (clk_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_d == LastBitCnt) begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end else begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[8:1]};
          end
        end
      end
      StAck: begin
        if (clk_fall) begin
          if (data_s) fail = 1'b1;
          else state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_s && data_s) state_d = StIdle;
      end
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // One watchdog covers every device-clocked phase.
    if (state_q inside {StShift, StAck, StWaitIdle}) begin
      if (cnt_q == ToLast) fail = 1'b1;
      else cnt_d = cnt_q + CntW'(1);
    end

    if (fail) begin
`ifdef PS2_TX_RESEND_EN
      if (retry_q < RetryW'(MAX_RETRY)) begin
        retry_d  = retry_q + RetryW'(1);
        shreg_d  = frame_q;
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = StInhibit;
      end else begin
        state_d = StFail;
      end
`else
      state_d = StFail;
`endif
    end

    if (!(state_d inside {StShift, StAck, StWaitIdle})) data_oe_d = (state_d == StReq);

    clk_oe_d   = state_d inside {StInhibit, StReq};
    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    done_d     = (state_q == StWaitIdle) && (state_d == StIdle);
    err_d      = (state_d == StFail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= '0;
      frame_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= retry_d;
      frame_q    <= frame_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = tx_ready_q;
  assign tx.busy     = busy_q;
  assign tx.done     = done_q;
  assign tx.err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on open-drain lines, table + random frames, corner sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 40;
  localparam int unsigned TO  = 3000;
  localparam int HALF = 20;
`ifdef PS2_TX_RESEND_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if u_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
`ifdef PS2_TX_RESEND_EN
    ,
    .MAX_RETRY(2)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (u_if.slave),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor sampled on the falling clock edge.
  longint cyc = 0;
  longint release_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_starts = 0, req_len = 0;
  int cur_inh = 0, last_inh_len = 0, late_ready = 0, err_oe = 0;
  logic prev_clk_oe = 1'b0, prev_pulse = 1'b0;
  bit host_clk_in_frame;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_pulse && u_if.tx_ready !== 1'b1) late_ready++;
    if (u_if.done === 1'b1) done_cnt++;
    if (u_if.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
      err_oe  = int'(ps2_clk_oe | ps2_data_oe);
    end
    if (u_if.done === 1'b1 && u_if.err === 1'b1) both_cnt++;
    if (ps2_clk_oe === 1'b1 && prev_clk_oe !== 1'b1) begin
      inh_starts++;
      cur_inh = 0;
    end
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) cur_inh++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) begin
      last_inh_len = cur_inh;
      req_len++;
    end
    if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) release_cyc = cyc;
    prev_clk_oe = ps2_clk_oe;
    prev_pulse  = (u_if.done === 1'b1) || (u_if.err === 1'b1);
  end

  // Reference: frame as the device sees it, {stop, odd parity, data, start}.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = b;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
  endtask

  // Device side: wait for the request, then clock nclk bits; optionally ACK on clock 11.
  task automatic dev_frame(input int nclk, input bit ack, output logic [10:0] bits,
                           output bit ok);
    int t = 0;
    bits = '1;
    ok   = 1'b0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 2 * INH + 100) begin
      tick(1);
      t++;
    end
    if (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0)) return;
    ok = 1'b1;
    bits[0] = ps2_data_in;
    tick(HALF);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        tick(5);
      end
      dev_clk_low = 1'b1;
      tick(HALF);
      if (i <= 10 && ps2_clk_oe !== 1'b0) host_clk_in_frame = 1'b1;
      dev_clk_low = 1'b0;
      tick(HALF / 2);
      if (i <= 10) bits[i] = ps2_data_in;
      tick(HALF / 2);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end(input int base, input int bound, output bit ok);
    int t = 0;
    while (done_cnt + err_cnt == base && t < bound) begin
      tick(1);
      t++;
    end
    ok = (done_cnt + err_cnt != base);
    tick(2);
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, input logic [10:0] exp,
                          input string tag);
    int d0 = done_cnt, e0 = err_cnt, i0 = inh_starts, r0 = req_len;
    int att = ack ? 1 : ATTEMPTS;
    logic [10:0] bits;
    bit ok, endok;
    host_clk_in_frame = 1'b0;
    check({tag, " ready before"}, u_if.tx_ready, 1);
    send(b);
    for (int a = 0; a < att; a++) begin
      dev_frame(11, ack, bits, ok);
      check({tag, " request seen"}, ok, 1);
      check({tag, " frame bits"}, bits, exp);
      check({tag, " inhibit length"}, last_inh_len, INH);
    end
    wait_end(d0 + e0, 300, endok);
    check({tag, " end reached"}, endok, 1);
    check({tag, " done pulses"}, done_cnt - d0, ack ? 1 : 0);
    check({tag, " err pulses"}, err_cnt - e0, ack ? 0 : 1);
    check({tag, " inhibit sequences"}, inh_starts - i0, att);
    check({tag, " req cycles"}, req_len - r0, att);
    check({tag, " host clk during frame"}, host_clk_in_frame, 0);
    check({tag, " idle ready/busy/oe"},
          {u_if.tx_ready, u_if.busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [10:0] bits;
    logic [7:0]  rb;
    bit ok, endok, rack;
    int d0, e0, i0;

    vecs[0] = '{data: 8'hED, ack: 1'b1, frame: {1'b1, 1'b1, 8'hED, 1'b0}};
    vecs[1] = '{data: 8'h01, ack: 1'b1, frame: {1'b1, 1'b0, 8'h01, 1'b0}};
    vecs[2] = '{data: 8'h00, ack: 1'b1, frame: {1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[3] = '{data: 8'hEE, ack: 1'b1, frame: {1'b1, 1'b1, 8'hEE, 1'b0}};
    vecs[4] = '{data: 8'h80, ack: 1'b1, frame: {1'b1, 1'b0, 8'h80, 1'b0}};
    vecs[5] = '{data: 8'hF4, ack: 1'b0, frame: {1'b1, 1'b0, 8'hF4, 1'b0}};

    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    tick(3);
    check("reset outputs", {u_if.tx_ready, u_if.busy, u_if.done, u_if.err, ps2_clk_oe,
                            ps2_data_oe}, 6'b100000);
    rst = 1'b0;
    tick(3);
    check("after reset outputs", {u_if.tx_ready, u_if.busy, u_if.done, u_if.err,
                                  ps2_clk_oe, ps2_data_oe}, 6'b100000);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i].data, vecs[i].ack, vecs[i].frame,
                                         $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_xfer(rb, rack, exp_frame(rb), $sformatf("rand%0d", i));
    end

    // Device never clocks: watchdog fires TO cycles after clock release.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    send(PS2_CMD_ECHO);
    wait_end(d0 + e0, ATTEMPTS * (int'(INH) + int'(TO) + 50) + 100, endok);
    check("timeout end reached", endok, 1);
    check("timeout err pulses", err_cnt - e0, 1);
    check("timeout done pulses", done_cnt - d0, 0);
    check("timeout latency", err_cyc - release_cyc, TO);
    check("timeout oe at err", err_oe, 0);
    check("timeout inhibit sequences", inh_starts - i0, ATTEMPTS);

`ifdef PS2_TX_RESEND_EN
    // NACK first, ACK on the retry.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    send(8'hA5);
    dev_frame(11, 1'b0, bits, ok);
    dev_frame(11, 1'b1, bits, ok);
    check("retry frame bits", bits, exp_frame(8'hA5));
    wait_end(d0 + e0, 300, endok);
    check("retry done pulses", done_cnt - d0, 1);
    check("retry err pulses", err_cnt - e0, 0);
    check("retry inhibit sequences", inh_starts - i0, 2);
`endif

    // Reset mid-frame after the fifth device clock.
    send(8'h00);
    dev_frame(5, 1'b0, bits, ok);
    tick(2);
    check("midframe busy/clk_oe/data_oe", {u_if.busy, ps2_clk_oe, ps2_data_oe}, 3'b101);
    d0 = done_cnt; e0 = err_cnt;
    #2 rst = 1'b1;
    #1;
    check("reset releases lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset ready/busy", {u_if.tx_ready, u_if.busy}, 2'b10);
    tick(3);
    rst = 1'b0;
    tick(50);
    check("reset no done/err", (done_cnt - d0) + (err_cnt - e0), 0);
    run_xfer(PS2_CMD_RESET, 1'b1, exp_frame(PS2_CMD_RESET), "post-reset");

    // A second request while busy is dropped, not queued.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    send(8'h3C);
    tick(5);
    check("busy during inhibit", {u_if.busy, u_if.tx_ready}, 2'b10);
    send(8'h55);
    dev_frame(11, 1'b1, bits, ok);
    check("busy-drop frame bits", bits, exp_frame(8'h3C));
    wait_end(d0 + e0, 300, endok);
    tick(INH + 60);
    check("busy-drop done pulses", done_cnt - d0, 1);
    check("busy-drop inhibit sequences", inh_starts - i0, 1);

    check("done and err together", both_cnt, 0);
    check("ready late after pulse", late_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the send direction of the keyboard link whose receive direction is handled by the existing keyboard decoder.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard PS/2 host-request sequence, then checks the device ACK.
- Drives the PS2_CLK/PS2_DATA pins open-drain through enables; the top level owns the tristates and feeds the same pins to the decoder.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles PS2_CLK is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles from clock release to ACK (15 ms); exceeding it aborts the transfer.
- MAX_RETRY, 2: resend attempts; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high in IDLE only; the byte is accepted when tx_valid && tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_data_in  in  1  raw PS2_DATA pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- busy  out  1  high in every non-IDLE state; the decoder ignores frames while it is high.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- err  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset values: tx_ready=1, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, state=IDLE, all counters and the shift register cleared.
- Reset during a transfer releases both lines immediately (asynchronous reset) and emits no done or err.
- Inputs pass through a 2-flop synchronizer. fall = synced clk was 1 on the previous cycle and is 0 now.
- IDLE: when tx_valid && tx_ready:
  - latch {odd parity, tx_data} into a 9-bit shift register;
  - odd parity = ~^tx_data;
  - go to INHIBIT.
- tx_valid while busy is ignored; the byte is not queued.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit = 0) for 1 cycle, then release clk_oe. Clear the timeout counter and the bit counter (bitcnt). Go to SHIFT.
- SHIFT: on each fall, bitcnt increments and the data line changes while clock is low:
  - bitcnt 1..9: data_oe = ~shreg[0], then shift right (8 data bits LSB first, then parity);
  - bitcnt 10: data_oe=0 (stop bit = 1); go to ACK.
- ACK: on the next fall, sample synced data:
  - 0 → go to WAIT_IDLE;
  - 1 → NACK, go to FAIL.
- WAIT_IDLE: when synced clk=1 and data=1, pulse done and go to IDLE.
- FAIL: both oe=0; pulse err, go to IDLE.
- Timeout counter runs in SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to FAIL from any of them.
- Outside INHIBIT and REQ, clk_oe=0 always. The host never drives PS2_CLK while the device clocks.
- done and err are never asserted in the same cycle. After either pulse, tx_ready is 1 on the next cycle.

Optional Feature:
- Macro PS2_TX_RESEND_EN.
- Defined: a failure (NACK or timeout) with retry count < MAX_RETRY increments the count and restarts at INHIBIT with the latched byte. err is not pulsed, tx_ready stays 0, and busy stays high. err pulses only after MAX_RETRY retries have also failed. The count clears on accept.
- Undefined: a failure goes directly to FAIL with no retry logic.

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, FAIL;
  - command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF;
  - ACK byte PS2_RSP_ACK=8'hFA.
- One sub-module, ps2_line_sync: 2-flop synchronizer for both lines plus the clk falling-edge detect. The decoder can share it.

Test Plan:
- Send 0xED with a BFM device clocking at 12.5 kHz that drives ACK=0 → measure clk_oe=1 for exactly 10000 cycles. Device samples start 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then one done pulse, no err, tx_ready=1.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Both end with done.
- Device never clocks after the request → err exactly TIMEOUT_CYCLES after clock release, both oe=0, no done.
- Device returns ACK bit = 1 → one err pulse. With PS2_TX_RESEND_EN, 3 full INHIBIT sequences occur before err, and an ACK on the 2nd attempt gives done with no err.
- Assert rst while bitcnt=5 → both oe=0 the same cycle, no done or err. A following 0xFF send completes normally.
- Pulse tx_valid with 0x55 while busy → ignored. Only the first byte appears on the line, with one done.
